// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary conv + max-pool engine.
// Holds the FSM state enum, kernel/pool sizes, flat-index helpers and popcount.
package bnn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int KSIZE = 3;
   localparam int PSIZE = 2;

   function automatic int fmap_idx(
      input int c, input int r, input int x,
      input int h, input int w
   );
      return c * h * w + r * w + x;
   endfunction

   function automatic int wgt_idx(
      input int o, input int c, input int kr,
      input int kc, input int in_ch
   );
      return (o * in_ch + c) * KSIZE * KSIZE + kr * KSIZE + kc;
   endfunction

   function automatic int thr_lsb(input int o, input int cnt_w);
      return o * cnt_w;
   endfunction

   function automatic logic [3:0] popcount9(input logic [8:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 9; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/bnn_window_popcount.sv
// Combinational 3x3 XNOR-popcount of one conv position for one filter.
// Ports: fmap/weights (flat), row/col conv position, filt index -> count.
module bnn_window_popcount
   import bnn_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int IN_CH  = 1,
   parameter int OUT_CH = 8,
   parameter int CNT_W  = 4,
   parameter int RW     = 5,
   parameter int CW     = 5,
   parameter int OW     = 3
) (
   input  logic [IN_CH*IMG_H*IMG_W-1:0] fmap,
   input  logic [OUT_CH*IN_CH*9-1:0]    weights,
   input  logic [RW-1:0]                row,
   input  logic [CW-1:0]                col,
   input  logic [OW-1:0]                filt,
   output logic [CNT_W-1:0]             count
);

   int         sum;
   int         rr;
   int         xx;
   logic       px;
   logic [8:0] taps;

   // Out-of-image taps read 0 but still XNOR with their weight.
   always_comb begin
      sum  = 0;
      rr   = 0;
      xx   = 0;
      px   = 1'b0;
      taps = '0;
      for (int c = 0; c < IN_CH; c++) begin
         for (int kr = 0; kr < KSIZE; kr++) begin
            for (int kc = 0; kc < KSIZE; kc++) begin
               rr = int'(row) + kr - 1;
               xx = int'(col) + kc - 1;
               px = 1'b0;
               if (rr >= 0 && rr < IMG_H &&
                   xx >= 0 && xx < IMG_W) begin
                  px = fmap[fmap_idx(c, rr, xx, IMG_H, IMG_W)];
               end
               taps[kr*KSIZE+kc] = ~(px ^
                  weights[wgt_idx(int'(filt), c, kr, kc, IN_CH)]);
            end
         end
         sum = sum + int'(popcount9(taps));
      end
      count = CNT_W'(sum);
   end

endmodule

// File: rtl/bnn_conv_pool.sv
// Binary 3x3 conv + threshold + 2x2 max-pool, one pooled bit per handshake.
// Ports: start/busy/done control, fmap_in/weights/thresholds (held while
// busy), out_valid/out_ready stream of out_bit + out_ch/out_row/out_col.
// Macro BNN_FMAP_REG_EN adds a fmap_out register of all pooled bits.
module bnn_conv_pool
   import bnn_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int IN_CH  = 1,
   parameter int OUT_CH = 8,
   parameter int CNT_W  = $clog2(IN_CH*9+1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [IN_CH*IMG_H*IMG_W-1:0]    fmap_in,
   input  logic [OUT_CH*IN_CH*9-1:0]       weights,
   input  logic [OUT_CH*CNT_W-1:0]         thresholds,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_bit,
   output logic [$clog2(OUT_CH)-1:0]       out_ch,
   output logic [$clog2(IMG_H/2)-1:0]      out_row,
   output logic [$clog2(IMG_W/2)-1:0]      out_col,
   output logic                            busy,
`ifdef BNN_FMAP_REG_EN
   output logic [OUT_CH*(IMG_H/2)*(IMG_W/2)-1:0] fmap_out,
`endif
   output logic                            done
);

   localparam int PH  = IMG_H / PSIZE;
   localparam int PW  = IMG_W / PSIZE;
   localparam int OW  = $clog2(OUT_CH);
   localparam int PRW = $clog2(PH);
   localparam int PCW = $clog2(PW);

   localparam logic [OW-1:0]  O_LAST  = OW'(OUT_CH - 1);
   localparam logic [PRW-1:0] PR_LAST = PRW'(PH - 1);
   localparam logic [PCW-1:0] PC_LAST = PCW'(PW - 1);

   state_t          state_q, state_d;
   logic [OW-1:0]   o_q, o_d;
   logic [PRW-1:0]  pr_q, pr_d;
   logic [PCW-1:0]  pc_q, pc_d;
   logic            fin_q, fin_d;
   logic            vld_q, vld_d;
   logic            bit_q, bit_d;
   logic [OW-1:0]   ch_q, ch_d;
   logic [PRW-1:0]  row_q, row_d;
   logic [PCW-1:0]  col_q, col_d;

   logic [CNT_W-1:0] cnt [4];
   logic [CNT_W-1:0] thr;
   logic [3:0]       act;
   logic             pooled;
   logic             load;
   logic             hs;
   logic             last_hs;

   for (genvar i = 0; i < 4; i++) begin : g_win
      bnn_window_popcount #(
         .IMG_W (IMG_W),
         .IMG_H (IMG_H),
         .IN_CH (IN_CH),
         .OUT_CH(OUT_CH),
         .CNT_W (CNT_W),
         .RW    (PRW + 1),
         .CW    (PCW + 1),
         .OW    (OW)
      ) u_win (
         .fmap   (fmap_in),
         .weights(weights),
         .row    ({pr_q, 1'(i / 2)}),
         .col    ({pc_q, 1'(i % 2)}),
         .filt   (o_q),
         .count  (cnt[i])
      );
   end

   assign thr = thresholds[thr_lsb(int'(o_q), CNT_W) +: CNT_W];

   always_comb begin
      act = '0;
      for (int i = 0; i < 4; i++) begin
         act[i] = (cnt[i] >= thr);
      end
      pooled = |act;
   end

   // fin_q marks that the final index has been loaded; counters freeze.
   assign load    = (state_q == RUN) && !fin_q && (!vld_q || out_ready);
   assign hs      = vld_q && out_ready;
   assign last_hs = hs && (ch_q == O_LAST) &&
                    (row_q == PR_LAST) && (col_q == PC_LAST);

   always_comb begin
      state_d = state_q;
      o_d     = o_q;
      pr_d    = pr_q;
      pc_d    = pc_q;
      fin_d   = fin_q;
      vld_d   = vld_q;
      bit_d   = bit_q;
      ch_d    = ch_q;
      row_d   = row_q;
      col_d   = col_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               o_d     = '0;
               pr_d    = '0;
               pc_d    = '0;
               fin_d   = 1'b0;
            end
         end
         RUN: begin
            if (last_hs) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (load) begin
         vld_d = 1'b1;
         bit_d = pooled;
         ch_d  = o_q;
         row_d = pr_q;
         col_d = pc_q;
         if (pc_q == PC_LAST) begin
            pc_d = '0;
            if (pr_q == PR_LAST) begin
               pr_d = '0;
               if (o_q == O_LAST) fin_d = 1'b1;
               else o_d = o_q + OW'(1);
            end else begin
               pr_d = pr_q + PRW'(1);
            end
         end else begin
            pc_d = pc_q + PCW'(1);
         end
      end else if (hs) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         o_q     <= '0;
         pr_q    <= '0;
         pc_q    <= '0;
         fin_q   <= 1'b0;
         vld_q   <= 1'b0;
         bit_q   <= 1'b0;
         ch_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         o_q     <= o_d;
         pr_q    <= pr_d;
         pc_q    <= pc_d;
         fin_q   <= fin_d;
         vld_q   <= vld_d;
         bit_q   <= bit_d;
         ch_q    <= ch_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   assign out_valid = vld_q;
   assign out_bit   = bit_q;
   assign out_ch    = ch_q;
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

`ifdef BNN_FMAP_REG_EN
   logic [OUT_CH*PH*PW-1:0] fmap_q, fmap_d;

   always_comb begin
      fmap_d = fmap_q;
      if (state_q == IDLE && start) begin
         fmap_d = '0;
      end else if (hs) begin
         fmap_d[int'(ch_q)*PH*PW + int'(row_q)*PW + int'(col_q)] = bit_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fmap_q <= '0;
      else     fmap_q <= fmap_d;
   end

   assign fmap_out = fmap_q;
`endif

endmodule

// File: tb/tb_bnn_conv_pool.sv
// Scoreboard bench for bnn_conv_pool at default parameters.
// Stimulus pushes expected pooled bits; a negedge monitor pops and compares.
module tb_bnn_conv_pool;

   localparam int W    = 28;
   localparam int H    = 28;
   localparam int IC   = 1;
   localparam int OC   = 8;
   localparam int CW   = 4;
   localparam int NOUT = OC * H * W / 4;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic out_ready;
   logic out_valid;
   logic out_bit;
   logic busy;
   logic done;
   logic [IC*H*W-1:0] fmap;
   logic [OC*IC*9-1:0] wts;
   logic [OC*CW-1:0] thr;
   logic [2:0] out_ch;
   logic [3:0] out_row;
   logic [3:0] out_col;
`ifdef BNN_FMAP_REG_EN
   logic [OC*14*14-1:0] fmap_out;
   logic [OC*14*14-1:0] fm_exp;
`endif

   bnn_conv_pool dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .fmap_in   (fmap),
      .weights   (wts),
      .thresholds(thr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bit   (out_bit),
      .out_ch    (out_ch),
      .out_row   (out_row),
      .out_col   (out_col),
      .busy      (busy),
`ifdef BNN_FMAP_REG_EN
      .fmap_out  (fmap_out),
`endif
      .done      (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_cnt = 0;
   int last_hs_cyc = 0;
   logic [11:0] q[$];
   bit rdy_rand = 1'b0;
   bit stall = 1'b0;
   logic [11:0] held;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      logic [11:0] cur;
      logic [11:0] e;
      cur = {out_ch, out_row, out_col, out_bit};
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (stall && out_valid) chk("hold_stable", 32'(cur), 32'(held));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("extra_output", 32'(cur), 32'hFFFF);
            end else begin
               e = q.pop_front();
               chk("output", 32'(cur), 32'(e));
            end
`ifdef BNN_FMAP_REG_EN
            fm_exp[int'(out_ch)*196 + int'(out_row)*14 + int'(out_col)] = out_bit;
`endif
            hs_cnt++;
            last_hs_cyc = cyc;
         end
         stall = out_valid && !out_ready;
         held  = cur;
      end
   end

   function automatic logic exp_bit(int kind, int o, int pr, int pc);
      case (kind)
         0: return 1'b1;
         1: return 1'b0;
         2: return (pr == 2 && pc == 2);
         default: return (o % 2 == 0);
      endcase
   endfunction

   task automatic setup(int kind);
      fmap = '0;
      wts  = '0;
      for (int o = 0; o < OC; o++) thr[o*CW +: CW] = 4'd9;
      case (kind)
         1: begin
            wts = '1;
            for (int o = 0; o < OC; o++) thr[o*CW +: CW] = 4'd1;
         end
         2: begin
            fmap[5*W+5] = 1'b1;
            for (int o = 0; o < OC; o++) wts[o*9+4] = 1'b1;
         end
         3: begin
            for (int o = 0; o < OC; o++)
               thr[o*CW +: CW] = (o % 2 == 1) ? 4'd10 : 4'd0;
         end
         default: ;
      endcase
      q.delete();
      for (int o = 0; o < OC; o++)
         for (int pr = 0; pr < H/2; pr++)
            for (int pc = 0; pc < W/2; pc++)
               q.push_back({3'(o), 4'(pr), 4'(pc), exp_bit(kind, o, pr, pc)});
      hs_cnt = 0;
`ifdef BNN_FMAP_REG_EN
      fm_exp = '0;
`endif
   endtask

   task automatic kick();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic run_pass(int kind, bit spurious);
      int n;
      setup(kind);
      kick();
      if (spurious) begin
         n = 0;
         while (hs_cnt < 50 && n < 5000) begin
            @(negedge clk);
            n++;
         end
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("busy_run_start", 32'(busy), 32'd1);
      end
      n = 0;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         chk("done_timeout", 32'(done), 32'd1);
         return;
      end
      chk("done_latency", 32'(cyc), 32'(last_hs_cyc + 1));
      chk("handshakes", 32'(hs_cnt), 32'(NOUT));
      chk("queue_empty", 32'(q.size()), 32'd0);
      chk("busy_in_done", 32'(busy), 32'd0);
      chk("valid_in_done", 32'(out_valid), 32'd0);
`ifdef BNN_FMAP_REG_EN
      checks++;
      if (fmap_out !== fm_exp) begin
         errors++;
         $display("FAIL fmap_out: got %h expected %h", fmap_out, fm_exp);
      end
`endif
      if (spurious) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 32'(done), 32'd0);
      @(negedge clk);
      chk("idle_after_done", 32'(busy), 32'd0);
   endtask

   task automatic abort_pass();
      int n;
      setup(0);
      kick();
      n = 0;
      while (hs_cnt < 100 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_100", 32'(hs_cnt >= 100), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_bit", 32'(out_bit), 32'd0);
      chk("abort_idx", 32'({out_ch, out_row, out_col}), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      setup(0);
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_bit", 32'(out_bit), 32'd0);
      chk("rst_idx", 32'({out_ch, out_row, out_col}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      run_pass(0, 1'b0);
      run_pass(1, 1'b0);
      run_pass(2, 1'b0);
      rdy_rand = 1'b1;
      run_pass(2, 1'b0);
      rdy_rand = 1'b0;
      run_pass(3, 1'b1);
      abort_pass();
      run_pass(2, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
